demux16_framer: RTL and testbench

DEMUX16_FRAMER -- requirements
Module: demux16_framer

---
 rtl/demux16_framer_pkg.sv | 14 +
 rtl/demux16_framer_lane_counter.sv | 23 ++
 rtl/demux16_framer.sv | 103 ++++++++++
 tb/tb_demux16_framer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/demux16_framer_pkg.sv
// Shared types and constants for the demux16_framer block.
package demux16_framer_pkg;

  localparam int unsigned LANES = 16;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/demux16_framer_lane_counter.sv
// Modulo-2**W lane counter with enable, synchronous clear and async reset.
module lane_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear outranks enable so an abort always restarts the scan at lane 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/demux16_framer.sv
// Serial-to-lane demultiplexer that assembles a word once every lane has been written.
module demux16_framer
  import demux16_framer_pkg::*;
#(
  parameter int unsigned SEL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  input  logic                  din,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  clear,
  output logic [2**SEL_W-1:0]   out,
  output logic [2**SEL_W-1:0]   filled,
  output logic [2**SEL_W-1:0]   word,
  output logic                  word_valid,
  output logic                  dup_err,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  busy
);

  localparam int unsigned N = 2**SEL_W;

  state_t           state;
  logic             frame_mode;
  logic             eff_mode;
  logic             wr;
  logic             dup;
  logic             complete;
  logic             cnt_en;
  logic [SEL_W-1:0] lane;
  logic [N-1:0]     onehot;
  logic [N-1:0]     next_filled;
  logic [N-1:0]     next_out;

  // Mode is only sampled on the first write of a frame; afterwards the latched copy rules.
  always_comb begin
    eff_mode    = (state == IDLE) ? mode : frame_mode;
    lane        = (eff_mode == MODE_SCAN) ? scan_idx : sel;
    wr          = in_valid & ~clear;
    onehot      = '0;
    for (int i = 0; i < int'(N); i++) begin
      onehot[i] = wr & (lane == SEL_W'(i));
    end
    dup         = |(onehot & filled);
    next_filled = filled | onehot;
    next_out    = (out & ~onehot) | ({N{din}} & onehot);
    complete    = wr & (&next_filled);
    cnt_en      = wr & (eff_mode == MODE_SCAN);
  end

  lane_counter #(
    .W (SEL_W)
  ) u_lane_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (clear),
    .count (scan_idx)
  );

  // Frame state, lane registers and the completed-word capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      frame_mode <= MODE_ADDR;
      out        <= '0;
      filled     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      dup_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      dup_err    <= 1'b0;
      if (clear) begin
        filled <= '0;
        state  <= IDLE;
        busy   <= 1'b0;
      end else if (wr) begin
        out     <= next_out;
        dup_err <= dup;
        if (state == IDLE) begin
          frame_mode <= mode;
        end
        // The completing write lands in word and immediately reopens the frame.
        if (complete) begin
          word       <= next_out;
          word_valid <= 1'b1;
          filled     <= '0;
          state      <= IDLE;
          busy       <= 1'b0;
        end else begin
          filled <= next_filled;
          state  <= FILL;
          busy   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux16_framer.sv
// Scoreboard bench for demux16_framer: directed frames, duplicates, aborts and async reset.
module tb_demux16_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        din = 1'b0;
  logic [3:0]  sel = '0;
  logic        clear = 1'b0;
  logic [15:0] out;
  logic [15:0] filled;
  logic [15:0] word;
  logic        word_valid;
  logic        dup_err;
  logic [3:0]  scan_idx;
  logic        busy;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          cyc = 0;

  logic [15:0] exp_words[$];
  logic        exp_dup[$];
  int          wv_cyc[$];

  demux16_framer #(.SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .din        (din),
    .sel        (sel),
    .clear      (clear),
    .out        (out),
    .filled     (filled),
    .word       (word),
    .word_valid (word_valid),
    .dup_err    (dup_err),
    .scan_idx   (scan_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops expected words and duplicate pulses as the DUT presents them.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      if (word_valid) begin
        wv_cyc.push_back(cyc);
        if (exp_words.size() == 0) check("word_valid_spurious", 32'(word_valid), 32'd0);
        else check("word", 32'(word), 32'(exp_words.pop_front()));
      end
      if (dup_err) begin
        if (exp_dup.size() == 0) check("dup_err_spurious", 32'(dup_err), 32'd0);
        else check("dup_err", 32'(dup_err), 32'(exp_dup.pop_front()));
      end
    end
  end

  task automatic wr(input logic m, input logic [3:0] s, input logic d);
    @(negedge clk);
    mode = m; sel = s; din = d; in_valid = 1'b1; clear = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear(input logic with_write);
    @(negedge clk);
    in_valid = with_write; sel = 4'd7; din = 1'b1; mode = 1'b0; clear = 1'b1;
  endtask

  initial begin
    logic [15:0] pat;

    // Async reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_filled", 32'(filled), 32'd0);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_dup_err", 32'(dup_err), 32'd0);
    check("rst_scan_idx", 32'(scan_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Addressed fill: ones on lanes 4, 5, 8.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_words.push_back(16'h0130);
      wr(1'b0, 4'(i), (i == 4 || i == 5 || i == 8));
      if (i == 0) begin
        idle();
        check("addr_busy_after_first", 32'(busy), 32'd1);
        check("addr_filled_after_first", 32'(filled), 32'h0001);
      end
    end
    idle();
    check("addr_filled_done", 32'(filled), 32'd0);
    check("addr_busy_done", 32'(busy), 32'd0);
    check("addr_word_hold", 32'(word), 32'h0130);

    // Scan fill of 16'h1010; mode toggled mid-frame must be ignored.
    pat = 16'h1010;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("scan_idx_step", 32'(scan_idx), 32'(i));
      if (i == 15) exp_words.push_back(16'h1010);
      mode = (i < 8); sel = 4'(i ^ 5); din = pat[i]; in_valid = 1'b1; clear = 1'b0;
    end
    idle();
    check("scan_idx_wrap", 32'(scan_idx), 32'd0);
    check("scan_filled_done", 32'(filled), 32'd0);

    // Duplicate write to lane 2.
    wr(1'b0, 4'd2, 1'b1);
    exp_dup.push_back(1'b1);
    wr(1'b0, 4'd2, 1'b0);
    idle();
    check("dup_out2", 32'(out[2]), 32'd0);
    check("dup_filled", 32'(filled), 32'h0004);
    do_clear(1'b0);
    idle();
    check("dup_clear_filled", 32'(filled), 32'd0);

    // Partial scan frame then abort: counter returns to 0.
    for (int i = 0; i < 3; i++) wr(1'b1, 4'd0, 1'b1);
    idle();
    check("scan_partial_idx", 32'(scan_idx), 32'd3);
    do_clear(1'b0);
    idle();
    check("scan_abort_idx", 32'(scan_idx), 32'd0);
    check("scan_abort_filled", 32'(filled), 32'd0);

    // Back-to-back frames FFFF then 0000 with no gap.
    wv_cyc.delete();
    for (int i = 0; i < 32; i++) begin
      if (i == 15) exp_words.push_back(16'hFFFF);
      if (i == 31) exp_words.push_back(16'h0000);
      wr(1'b0, 4'(i % 16), (i < 16));
    end
    idle();
    check("b2b_pulses", 32'(wv_cyc.size()), 32'd2);
    if (wv_cyc.size() == 2) check("b2b_spacing", 32'(wv_cyc[1] - wv_cyc[0]), 32'd16);
    check("b2b_word2", 32'(word), 32'h0000);

    // Seven writes, then clear coincident with a write.
    for (int i = 0; i < 7; i++) wr(1'b0, 4'(i), 1'b1);
    do_clear(1'b1);
    idle();
    check("abort_filled", 32'(filled), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_word_kept", 32'(word), 32'h0000);
    check("abort_out_lane7_dropped", 32'(out[7]), 32'd0);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0) exp_words.push_back(16'hAAAA);
      wr(1'b0, 4'(i), i[0]);
    end
    idle();
    check("abort_next_word", 32'(word), 32'hAAAA);

    // Async reset mid-frame with filled = 00FF.
    for (int i = 0; i < 8; i++) wr(1'b0, 4'(i), 1'b1);
    idle();
    check("pre_rst_filled", 32'(filled), 32'h00FF);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_filled", 32'(filled), 32'd0);
    check("mid_rst_word", 32'(word), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_scan_idx", 32'(scan_idx), 32'd0);
    @(negedge clk) rst = 1'b0;
    pat = 16'hC3A5;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_words.push_back(16'hC3A5);
      wr(1'b1, 4'd0, pat[i]);
    end
    idle();
    check("post_rst_word", 32'(word), 32'hC3A5);
    idle();

    check("words_outstanding", 32'(exp_words.size()), 32'd0);
    check("dups_outstanding", 32'(exp_dup.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
